// File: rtl/sprite_pkg.sv
// Shared sprite constants, pixel code type and the loader FSM state encoding.
package sprite_pkg;

  localparam int unsigned SPR_H_SIZE     = 32;
  localparam int unsigned SPR_V_SIZE     = 32;
  localparam int unsigned SPR_FRAME_SIZE = 1024;
  localparam int unsigned SPR_PW         = 3;
  localparam int unsigned SPR_PPW        = 10;

  typedef logic [2:0] pix_code_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFin
  } loader_state_e;

endpackage

// File: rtl/loader_word_fifo.sv
// Small synchronous word FIFO with full/empty flags and a single-cycle flush.
module loader_word_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned   PtrW   = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, wptr_d;
  logic [PtrW:0]    rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrOne;
      if (pop_ok)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sprite_ram_loader.sv
// Unpacks packed pixel words into single-pixel sprite RAM writes.
// Optional SPRITE_LOADER_CKSUM_EN adds a 16-bit running sum of written pixel codes.
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR       = 11,
  parameter int unsigned PW         = 3,
  parameter int unsigned PPW        = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_start,
  input  logic [ADDR-1:0] cfg_base_addr,
  input  logic [ADDR:0]   cfg_count,
  input  logic            wr_valid,
  input  logic [31:0]     wr_data,
  output logic            wr_ready,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [PW-1:0]   pixel_in
`ifdef SPRITE_LOADER_CKSUM_EN
  ,
  output logic [15:0]     cksum
`endif
);

  localparam int unsigned       FieldW    = $clog2(PPW);
  localparam logic [ADDR:0]     PixOne    = (ADDR + 1)'(1);
  localparam logic [FieldW-1:0] FieldOne  = FieldW'(1);
  localparam logic [FieldW-1:0] FieldLast = FieldW'(PPW - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR-1:0]   base_q, base_d;
  logic [ADDR:0]     count_q, count_d;
  logic [ADDR:0]     pix_q, pix_d;
  logic [FieldW-1:0] field_q, field_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [PW-1:0]     pixel_q, pixel_d;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [31:0]       fifo_head;
  logic              start_acc, emit, last_pix;
  logic [PW-1:0]     field_pix;

  loader_word_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (wr_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  if (PPW * PW < 32) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^fifo_head[31:PPW*PW];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = (cfg_count == '0) ? StFin : StLoad;
      StLoad:  if (emit && last_pix) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy       = 1'b0;
    wr_ready   = 1'b0;
    fifo_flush = 1'b0;
    start_acc  = 1'b0;
    unique case (state_q)
      StIdle: start_acc = cfg_start;
      StLoad: begin
        busy     = 1'b1;
        wr_ready = !fifo_full;
      end
      StFin: begin
        busy       = 1'b1;
        fifo_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    field_pix = '0;
    for (int unsigned i = 0; i < PPW; i++) begin
      if (field_q == FieldW'(i)) field_pix = fifo_head[PW*i +: PW];
    end
  end

  assign emit      = (state_q == StLoad) && !fifo_empty;
  assign last_pix  = (pix_q + PixOne) == count_q;
  assign fifo_push = wr_valid && wr_ready;
  // Drop the rest of the head word once the final pixel has gone out.
  assign fifo_pop  = emit && ((field_q == FieldLast) || last_pix);

  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    pix_d   = pix_q;
    field_d = field_q;
    done_d  = done_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    pixel_d = pixel_q;
    if (start_acc) begin
      base_d  = cfg_base_addr;
      count_d = cfg_count;
      pix_d   = '0;
      field_d = '0;
      done_d  = 1'b0;
    end
    if (emit) begin
      we_d    = 1'b1;
      addr_d  = base_q + pix_q[ADDR-1:0];
      pixel_d = field_pix;
      pix_d   = pix_q + PixOne;
      field_d = (field_q == FieldLast) ? '0 : field_q + FieldOne;
    end
    if (state_q == StFin) begin
      done_d  = 1'b1;
      field_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q  <= '0;
      count_q <= '0;
      pix_q   <= '0;
      field_q <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      pixel_q <= '0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      pix_q   <= pix_d;
      field_q <= field_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      pixel_q <= pixel_d;
    end
  end

  assign done     = done_q;
  assign we       = we_q;
  assign addr_w   = addr_q;
  assign pixel_in = pixel_q;

`ifdef SPRITE_LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start_acc) cksum_d = '0;
    else if (emit) cksum_d = cksum_q + 16'(field_pix);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cksum_q <= '0;
    else          cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`endif

endmodule
